param_2421_counter: RTL and testbench
=====================================

// Module: param_2421_counter
// PURPOSE
// - Parametrised multi-digit decimal counter; each digit uses 2421 (Aiken) code.
// - Successor to the single-digit 2421 counter. Adds:
//   - N cascaded digits
//   - up/down counting
//   - synchronous parallel load with code checking
//   - wrap or saturate selection
//   - terminal-count and wrap flags
// - Sits in the display/timer path and feeds the 2421 decoders.
// PARAMETERS
// - DIGITS  4  number of cascaded decimal digits, 1..8
// - WRAP    1  1: wrap 9..9 <-> 0..0; 0: saturate at the end of range
// PORTS
// - c         in   1         clock; all state changes on rising edge
// - rst       in   1         reset, asynchronous, active-low
// - en        in   1         count enable
// - up        in   1         1: count up, 0: count down
// - load      in   1         synchronous parallel load strobe
// - load_val  in   4*DIGITS  value to load; digit k = load_val[4k+3:4k]
// - q         out  4*DIGITS  count; digit 0 = q[3:0] = least significant
// - tc        out  1         terminal count, combinational
// - wrap      out  1         registered 1-cycle pulse on a wrap event
// - err       out  1         registered 1-cycle pulse when a load is rejected
// BEHAVIOUR
// - One clock: c. Reset is asynchronous and active-low: rst=0 immediately forces
//   q=0, wrap=0, err=0.
// - 2421 digit codes, bit weights b3..b0 = 2,4,2,1:
//   - 0=0000 1=0001 2=0010 3=0011 4=0100
//   - 5=1011 6=1100 7=1101 8=1110 9=1111
//   - The other 6 codes are illegal: 0101 0110 0111 1000 1001 1010.
// - Priority per edge: load > en > hold.
// - Load:
//   - All digits legal: q <= load_val next edge, err=0.
//   - Any digit illegal: q holds, err=1 for one cycle, no count that cycle.
// - Count (en=1, load=0), latency one cycle:
//   - Up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
//   - Down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
//   - The carry/borrow ripple is combinational within one cycle.
// - Range ends: all-9 (q = all ones) when up; all-0 when down.
//   - tc = en & ~load & (up ? q==all-9 : q==all-0).
// - At a range end with en=1:
//   - WRAP=1: q wraps to the opposite end; wrap=1 on the next cycle.
//   - WRAP=0: q holds; wrap stays 0.
// - When en=0 and load=0, q holds. Toggling up mid-count takes effect on the next edge.
// - q is only ever a legal 2421 code: reset, count and accepted load all preserve this.
// - Illegal state (e.g. injected by force) while counting: the digit goes to 0,
//   with no carry or borrow.
// - Reset asserted mid-count or mid-load overrides everything asynchronously.
//   Counting resumes from 0 on the first edge after rst=1.
// TESTING (DIGITS=2 unless noted)
// - Reset: rst=0 for 3 edges with en=1 -> q=8'h00, wrap=0, err=0 throughout.
// - Up sequence: from 8'h00, en=1, up=1, 10 edges
//   -> digit 0 steps 0,1,2,3,4,B,C,D,E,F, then q=8'h10.
// - Wrap: load 8'hFF, en=1, up=1 -> tc=1 before the edge; q=8'h00 and wrap=1
//   after one edge. Same test with WRAP=0 -> q stays 8'hFF, wrap=0.
// - Down/borrow: load 8'h10, up=0, en=1 -> q=8'h0F; at 8'h00, WRAP=1 -> q=8'hFF.
// - Bad load: q=8'h13, load_val=8'h5A -> err=1 one cycle, q stays 8'h13.
//   Load 8'hB4 -> q=8'hB4, err=0.
// - Collisions: load=1 and en=1 on the same edge -> the load wins.
//   rst pulsed low mid-count -> q=0 without waiting for an edge.

Source files
------------

// File: rtl/param_2421_counter.sv
// param_2421_counter
// Multi-digit decimal counter in which every digit is held in 2421 (Aiken)
// code. It counts up or down, accepts a checked parallel load, and either
// wraps around or saturates at the ends of its range. Digit 0 is the least
// significant digit and sits in q_o[3:0].
module param_2421_counter #(
    parameter int DIGITS = 4,     // number of cascaded decimal digits, 1..8
    parameter bit WRAP   = 1'b1   // 1: wrap at the range ends, 0: saturate
) (
    input  logic                  c_i,         // clock, rising edge
    input  logic                  rst_ni,      // asynchronous, active-low
    input  logic                  en_i,        // count enable
    input  logic                  up_i,        // 1: up, 0: down
    input  logic                  load_i,      // synchronous parallel load
    input  logic [4*DIGITS-1:0]   load_val_i,  // value to load
    output logic [4*DIGITS-1:0]   q_o,         // current count
    output logic                  tc_o,        // terminal count (combinational)
    output logic                  wrap_o,      // one-cycle pulse after a wrap
    output logic                  err_o        // one-cycle pulse after a bad load
);

    localparam int W = 4 * DIGITS;

    // The six codes 0101..1010 carry no decimal meaning in 2421.
    function automatic logic is_legal(input logic [3:0] code);
        return (code <= 4'd4) || (code >= 4'd11);
    endfunction

    // Successor of a legal digit; 9 (1111) rolls to 0. Illegal codes go to 0.
    function automatic logic [3:0] inc_2421(input logic [3:0] code);
        logic [3:0] res;
        res = 4'h0;
        case (code)
            4'h0, 4'h1, 4'h2, 4'h3: res = code + 4'd1;
            4'h4:                   res = 4'hB;
            4'hB, 4'hC, 4'hD, 4'hE: res = code + 4'd1;
            default:                res = 4'h0;
        endcase
        return res;
    endfunction

    // Predecessor of a legal digit; 0 rolls to 9 (1111). Illegal codes go to 0.
    function automatic logic [3:0] dec_2421(input logic [3:0] code);
        logic [3:0] res;
        res = 4'h0;
        case (code)
            4'h0:                   res = 4'hF;
            4'h1, 4'h2, 4'h3, 4'h4: res = code - 4'd1;
            4'hB:                   res = 4'h4;
            4'hC, 4'hD, 4'hE, 4'hF: res = code - 4'd1;
            default:                res = 4'h0;
        endcase
        return res;
    endfunction

    logic [W-1:0]      q_q, q_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;

    // carry[k] is the carry (up) or borrow (down) entering digit k.
    logic [DIGITS:0]   carry;
    logic [W-1:0]      count_val;
    logic [DIGITS-1:0] load_ok;
    logic              at_end;

    assign carry[0] = 1'b1;

    // Per-digit step logic and the ripple chain.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            logic       cur_legal;
            logic       at_limit;

            assign cur       = q_q[4*gi +: 4];
            assign cur_legal = is_legal(cur);
            // 1111 and 0000 are both legal, so an illegal digit never
            // propagates a carry or borrow.
            assign at_limit  = up_i ? (cur == 4'hF) : (cur == 4'h0);
            assign carry[gi+1] = carry[gi] & at_limit;

            // An illegal digit is cleared on any counting edge; a legal digit
            // steps only when the ripple reaches it.
            always_comb begin
                count_val[4*gi +: 4] = cur;
                if (!cur_legal) begin
                    count_val[4*gi +: 4] = 4'h0;
                end else if (carry[gi]) begin
                    count_val[4*gi +: 4] = up_i ? inc_2421(cur) : dec_2421(cur);
                end
            end

            assign load_ok[gi] = is_legal(load_val_i[4*gi +: 4]);
        end
    endgenerate

    // Range end: all-9 is all ones when counting up, all-0 when counting down.
    assign at_end = up_i ? (q_q == {W{1'b1}}) : (q_q == {W{1'b0}});
    assign tc_o   = en_i & ~load_i & at_end;

    // Next-state selection: load beats count beats hold.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load_i) begin
            if (&load_ok) begin
                q_d = load_val_i;
            end else begin
                err_d = 1'b1;
            end
        end else if (en_i) begin
            if (carry[DIGITS]) begin
                // Ripple ran off the top digit: this is a range-end event.
                if (WRAP) begin
                    q_d    = count_val;
                    wrap_d = 1'b1;
                end
            end else begin
                q_d = count_val;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge c_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q_o    = q_q;
    assign wrap_o = wrap_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_param_2421_counter.sv
// Bench for param_2421_counter with two digits, run as a wrapping and a
// saturating instance side by side. The reference model keeps each count as a
// plain integer 0..99 and converts it to 2421 code through a lookup table.
module tb_param_2421_counter;

    localparam int D   = 2;
    localparam int MAX = 99;

    logic          c;
    logic          rst_n;
    logic          en;
    logic          up;
    logic          load;
    logic [4*D-1:0] load_val;
    logic [4*D-1:0] q_w, q_s;
    logic          tc_w, tc_s, wrap_w, wrap_s, err_w, err_s;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int val_w, val_s;
    logic exp_wrap_w, exp_wrap_s, exp_err;

    logic [3:0] tab [10] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                             4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    param_2421_counter #(.DIGITS(D), .WRAP(1'b1)) dut_w (
        .c_i(c), .rst_ni(rst_n), .en_i(en), .up_i(up), .load_i(load),
        .load_val_i(load_val), .q_o(q_w), .tc_o(tc_w), .wrap_o(wrap_w),
        .err_o(err_w)
    );

    param_2421_counter #(.DIGITS(D), .WRAP(1'b0)) dut_s (
        .c_i(c), .rst_ni(rst_n), .en_i(en), .up_i(up), .load_i(load),
        .load_val_i(load_val), .q_o(q_s), .tc_o(tc_s), .wrap_o(wrap_s),
        .err_o(err_s)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4*D-1:0] enc(input int v);
        logic [4*D-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[4*k +: 4] = tab[x % 10];
            x = x / 10;
        end
        return r;
    endfunction

    // Returns 1 and the integer value if every digit is a valid code.
    function automatic logic decode(input logic [4*D-1:0] code, output int v);
        int scale;
        logic ok;
        logic found;
        v = 0;
        scale = 1;
        ok = 1'b1;
        for (int k = 0; k < D; k++) begin
            found = 1'b0;
            for (int j = 0; j < 10; j++) begin
                if (tab[j] == code[4*k +: 4]) begin
                    v = v + j * scale;
                    found = 1'b1;
                end
            end
            if (!found) ok = 1'b0;
            scale = scale * 10;
        end
        return ok;
    endfunction

    function automatic logic exp_tc(input int v);
        return en & ~load & (up ? (v == MAX) : (v == 0));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one counting step of the model with wrap or saturate behaviour.
    task automatic model_count(inout int v, input logic do_wrap,
                               output logic wrapped);
        wrapped = 1'b0;
        if (up) begin
            if (v == MAX) begin
                if (do_wrap) begin v = 0; wrapped = 1'b1; end
            end else begin
                v = v + 1;
            end
        end else begin
            if (v == 0) begin
                if (do_wrap) begin v = MAX; wrapped = 1'b1; end
            end else begin
                v = v - 1;
            end
        end
    endtask

    // One clock: check tc before the edge, then all registered outputs after.
    task automatic step();
        int lv;
        #1;
        check("tc_w", {31'd0, tc_w}, {31'd0, exp_tc(val_w)});
        check("tc_s", {31'd0, tc_s}, {31'd0, exp_tc(val_s)});
        @(posedge c);
        #1;
        exp_wrap_w = 1'b0;
        exp_wrap_s = 1'b0;
        exp_err    = 1'b0;
        if (load) begin
            if (decode(load_val, lv)) begin
                val_w = lv;
                val_s = lv;
            end else begin
                exp_err = 1'b1;
            end
        end else if (en) begin
            model_count(val_w, 1'b1, exp_wrap_w);
            model_count(val_s, 1'b0, exp_wrap_s);
        end
        check("q_w",    {24'd0, q_w},    {24'd0, enc(val_w)});
        check("q_s",    {24'd0, q_s},    {24'd0, enc(val_s)});
        check("wrap_w", {31'd0, wrap_w}, {31'd0, exp_wrap_w});
        check("wrap_s", {31'd0, wrap_s}, {31'd0, exp_wrap_s});
        check("err_w",  {31'd0, err_w},  {31'd0, exp_err});
        check("err_s",  {31'd0, err_s},  {31'd0, exp_err});
    endtask

    task automatic do_load(input logic [4*D-1:0] v, input logic with_en);
        load = 1'b1;
        load_val = v;
        en = with_en;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        up = 1'b1;
        load = 1'b0;
        load_val = '0;
        val_w = 0;
        val_s = 0;

        // Reset held across three edges with counting requested
        for (int i = 0; i < 3; i++) begin
            @(posedge c);
            #1;
            check("rst_q_w",    {24'd0, q_w}, 32'h00);
            check("rst_q_s",    {24'd0, q_s}, 32'h00);
            check("rst_wrap",   {31'd0, wrap_w}, 32'd0);
            check("rst_err",    {31'd0, err_w}, 32'd0);
        end
        rst_n = 1'b1;

        // Up sequence through digit 0, then the carry into digit 1
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("up_seq_end", {24'd0, q_w}, 32'h10);

        // Wrap at all-9 vs saturation
        do_load(8'hFF, 1'b0);
        en = 1'b1;
        up = 1'b1;
        #1;
        check("tc_at_ff", {31'd0, tc_w}, 32'd1);
        step();
        check("wrap_q_w", {24'd0, q_w}, 32'h00);
        check("wrap_flag", {31'd0, wrap_w}, 32'd1);
        check("sat_q_s",  {24'd0, q_s}, 32'hFF);
        check("sat_flag", {31'd0, wrap_s}, 32'd0);

        // Borrow across digits, then wrap downward from all-0
        do_load(8'h10, 1'b0);
        en = 1'b1;
        up = 1'b0;
        step();
        check("borrow_q", {24'd0, q_w}, 32'h0F);
        do_load(8'h00, 1'b0);
        en = 1'b1;
        up = 1'b0;
        step();
        check("down_wrap", {24'd0, q_w}, 32'hFF);
        check("down_sat",  {24'd0, q_s}, 32'h00);

        // Rejected then accepted load
        do_load(8'h13, 1'b0);
        do_load(8'h5A, 1'b0);
        check("bad_err", {31'd0, err_w}, 32'd1);
        check("bad_hold", {24'd0, q_w}, 32'h13);
        do_load(8'hB4, 1'b0);
        check("good_q", {24'd0, q_w}, 32'hB4);
        check("good_err", {31'd0, err_w}, 32'd0);

        // Load wins over count on the same edge
        up = 1'b1;
        do_load(8'h2C, 1'b1);
        check("load_wins", {24'd0, q_w}, 32'h2C);

        // Asynchronous reset in the middle of counting
        en = 1'b1;
        up = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_w", {24'd0, q_w}, 32'h00);
        check("async_rst_s", {24'd0, q_s}, 32'h00);
        @(posedge c);
        #1;
        rst_n = 1'b1;
        val_w = 0;
        val_s = 0;
        step();
        check("resume_q", {24'd0, q_w}, 32'h01);

        // Random traffic against the integer model
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1);
            load = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = enc($urandom_range(0, MAX));
                1:       load_val = $urandom_range(0, 1) ? enc(MAX) : enc(0);
                default: load_val = 8'($urandom);
            endcase
            step();
        end
        load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
